prog_loader: RTL
================

// Module: prog_loader
// PURPOSE
//  Parametrised program-memory loader: accepts a valid/ready word stream and writes it into
//  program memory at BASE_ADDR + i*STRIDE. It holds the core in reset while loading, optionally
//  reads the image back and checks it, then releases the core. Sits between a host/boot stream
//  and the ProgMem write port, and drives the core reset in the top level.
// PARAMETERS
//  DATA_W     32    instruction word width
//  ADDR_W     32    program-memory byte-address width
//  DEPTH      1024  max words per image
//  BASE_ADDR  0     byte address of word 0
//  STRIDE     4     byte-address increment per word
//  VERIFY_EN  1     1: read back and compare checksum before release; 0: skip
// PORTS
//  clk         in   1                      clock, rising edge
//  rst         in   1                      synchronous, active-high reset
//  start       in   1                      pulse: begin load of word_count words
//  word_count  in   $clog2(DEPTH+1)        image length, sampled on accepted start
//  s_valid     in   1                      stream word valid
//  s_data      in   DATA_W                 stream word
//  s_ready     out  1                      loader accepts word
//  mem_we      out  1                      ProgMem write strobe
//  mem_re      out  1                      ProgMem read strobe (verify)
//  mem_addr    out  ADDR_W                 ProgMem byte address
//  mem_wdata   out  DATA_W                 ProgMem write data
//  mem_rdata   in   DATA_W                 ProgMem read data, valid 1 cycle after mem_re
//  core_rst    out  1                      active-high reset to core
//  busy        out  1                      in LOAD or VERIFY
//  done        out  1                      level, high in RUN
//  error       out  1                      level, high in ERR
//  checksum    out  DATA_W                 sum mod 2^DATA_W of accepted words
// BEHAVIOUR
//  - Reset (any state, mid-operation included): state=IDLE, core_rst=1, s_ready=0, mem_we=0,
//    mem_re=0, busy=0, done=0, error=0, checksum=0, word index=0. rst has priority over all inputs.
//  - States: IDLE, LOAD, VERIFY, RUN, ERR. core_rst=1 in every state except RUN.
//  - IDLE/RUN/ERR + start: word_count==0 or >DEPTH -> ERR; otherwise -> LOAD, index=0,
//    checksum=0, count latched. start in LOAD/VERIFY is ignored. start in RUN reasserts core_rst
//    on the next cycle (reload).
//  - LOAD: s_ready=1. A beat is the cycle with s_valid&&s_ready. In that same cycle
//    mem_we=1 (combinational), mem_addr=BASE_ADDR+index*STRIDE (truncated to ADDR_W),
//    mem_wdata=s_data. checksum+=s_data and index++ are registered. s_valid=0 -> no write,
//    and no state change.
//  - Last beat (index==count-1): VERIFY_EN=0 -> RUN next cycle. VERIFY_EN=1 -> VERIFY, index=0.
//  - VERIFY: mem_re=1 for index 0..count-1, one per cycle; mem_addr as in LOAD. mem_rdata is
//    summed one cycle later. One cycle after the last read data, compare the read-back sum with
//    checksum: equal -> RUN, else -> ERR. Latency from last beat to RUN is count+2 cycles.
//  - RUN: core_rst=0, done=1. checksum holds until the next accepted start.
//  - ERR: error=1, core_rst=1. Cleared only by a valid start (retry) or by rst.
//  - mem_we and mem_re are never both high. All address and sum arithmetic wraps modulo width.
// STRUCTURE
//  - defines.vh: LDR_IDLE/LDR_LOAD/LDR_VERIFY/LDR_RUN/LDR_ERR 3-bit state encodings.
//  - One sub-module, prog_loader_csum: a clear/enable accumulator. It is instantiated twice,
//    once for the write sum and once for the read-back sum.
//  - FSM, index counter and address generator stay in prog_loader.
// TESTING
//  1. VERIFY_EN=1. start, count=3; stream 0x00500193, 0x00200213, 0x004182B3 ->
//     writes to 0x0, 0x4, 0x8; checksum=0x00B18659; RUN 5 cycles after the last beat;
//     after the core runs, x5==7.
//  2. Same image with s_valid toggling 1,0,1,0,1 -> no write on idle cycles; same addresses
//     and checksum.
//  3. Memory model corrupts the word at 0x4 on read-back -> ERR, error=1, core_rst stays 1.
//     Then start with good memory -> RUN.
//  4. start with count=0, then with count=DEPTH+1 -> ERR both times, no mem_we pulse.
//  5. rst asserted after 2 of 3 beats -> next cycle IDLE, core_rst=1, checksum=0.
//     A fresh load then completes normally.
//  6. VERIFY_EN=0, BASE_ADDR=0x100, STRIDE=4, count=2 -> addresses 0x100, 0x104; RUN the
//     cycle after the last beat; mem_re never asserted.

Source files
------------

// File: rtl/prog_loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : prog_loader_pkg                                                 |
// | Purpose  : Shared state encodings for the program-memory loader.           |
// | Contents : LDR_* 3-bit state codes and the ldr_state_e enum built on them. |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package prog_loader_pkg;

    localparam logic [2:0] LDR_IDLE   = 3'd0;
    localparam logic [2:0] LDR_LOAD   = 3'd1;
    localparam logic [2:0] LDR_VERIFY = 3'd2;
    localparam logic [2:0] LDR_RUN    = 3'd3;
    localparam logic [2:0] LDR_ERR    = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = LDR_IDLE,
        ST_LOAD   = LDR_LOAD,
        ST_VERIFY = LDR_VERIFY,
        ST_RUN    = LDR_RUN,
        ST_ERR    = LDR_ERR
    } ldr_state_e;

endpackage
`default_nettype wire

// File: rtl/prog_loader_csum.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : prog_loader_csum                                                |
// | Purpose  : Clear/enable accumulator, sum modulo 2^DATA_W.                  |
// | Ports    : clk, rst (sync, active-high), clr (sync clear), en (add din),   |
// |            din (addend), sum (registered running sum)                      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module prog_loader_csum #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] sum
);

    logic [DATA_W-1:0] r_sum;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_sum <= '0;
        end else if (en) begin
            r_sum <= r_sum + din;
        end
    end

    assign sum = r_sum;

endmodule
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : prog_loader                                                     |
// | Purpose  : Streams an image into program memory at BASE_ADDR + i*STRIDE,   |
// |            holds the core in reset while loading, optionally reads the     |
// |            image back and compares sums, then releases the core.           |
// | Ports    : start/word_count   - load request and image length              |
// |            s_valid/s_data/s_ready - word stream in                         |
// |            mem_we/mem_re/mem_addr/mem_wdata/mem_rdata - ProgMem port       |
// |            core_rst/busy/done/error/checksum - status                      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter int                DEPTH     = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                STRIDE    = 4,
    parameter int                VERIFY_EN = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [$clog2(DEPTH+1)-1:0] word_count,
    input  logic                       s_valid,
    input  logic [DATA_W-1:0]          s_data,
    output logic                       s_ready,
    output logic                       mem_we,
    output logic                       mem_re,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic [DATA_W-1:0]          mem_rdata,
    output logic                       core_rst,
    output logic                       busy,
    output logic                       done,
    output logic                       error,
    output logic [DATA_W-1:0]          checksum
);

    localparam int CNT_W = $clog2(DEPTH+1);

    ldr_state_e        r_state;
    ldr_state_e        w_state_next;
    logic [CNT_W-1:0]  r_index;
    logic [CNT_W-1:0]  r_count;
    logic              r_rd_valid;     // read data for last cycle's mem_re is on mem_rdata
    logic [DATA_W-1:0] w_wsum;
    logic [DATA_W-1:0] w_rsum;

    logic w_idle_like;
    logic w_start_ok;
    logic w_start_accept;
    logic w_beat;
    logic w_last_beat;
    logic w_rd_phase;
    logic w_drain;

    assign w_idle_like    = (r_state == ST_IDLE) || (r_state == ST_RUN) || (r_state == ST_ERR);
    assign w_start_ok     = (word_count != '0) && (word_count <= CNT_W'(DEPTH));
    assign w_start_accept = start && w_idle_like && w_start_ok;
    assign w_beat         = (r_state == ST_LOAD) && s_valid;
    assign w_last_beat    = w_beat && (r_index == r_count - 1'b1);
    // Reads issue while index < count; the index==count cycle only collects the last datum.
    assign w_rd_phase     = (r_state == ST_VERIFY) && (r_index != r_count);
    assign w_drain        = (r_state == ST_VERIFY) && (r_index == r_count);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_index    <= '0;
            r_count    <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_rd_valid <= w_rd_phase;
            if (w_start_accept) begin
                r_index <= '0;
                r_count <= word_count;
            end else if (w_beat) begin
                r_index <= w_last_beat ? '0 : r_index + 1'b1;
            end else if (w_rd_phase) begin
                r_index <= r_index + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        s_ready      = 1'b0;
        mem_we       = 1'b0;
        mem_re       = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        error        = 1'b0;
        core_rst     = 1'b1;
        case (r_state)
            ST_IDLE, ST_RUN, ST_ERR: begin
                if (r_state == ST_RUN) begin
                    core_rst = 1'b0;
                    done     = 1'b1;
                end
                if (r_state == ST_ERR) begin
                    error = 1'b1;
                end
                if (start) begin
                    w_state_next = w_start_ok ? ST_LOAD : ST_ERR;
                end
            end
            ST_LOAD: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                mem_we  = s_valid;
                if (w_last_beat) begin
                    w_state_next = (VERIFY_EN != 0) ? ST_VERIFY : ST_RUN;
                end
            end
            ST_VERIFY: begin
                busy   = 1'b1;
                mem_re = w_rd_phase;
                // Fold the final datum in combinationally so RUN lands count+2 after the last beat.
                if (w_drain) begin
                    w_state_next = ((w_rsum + mem_rdata) == w_wsum) ? ST_RUN : ST_ERR;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign mem_addr  = BASE_ADDR + ADDR_W'(r_index) * ADDR_W'(STRIDE);
    assign mem_wdata = s_data;
    assign checksum  = w_wsum;

    prog_loader_csum #(.DATA_W(DATA_W)) u_wsum (
        .clk (clk),
        .rst (rst),
        .clr (w_start_accept),
        .en  (w_beat),
        .din (s_data),
        .sum (w_wsum)
    );

    prog_loader_csum #(.DATA_W(DATA_W)) u_rsum (
        .clk (clk),
        .rst (rst),
        .clr (w_start_accept),
        .en  (r_rd_valid),
        .din (mem_rdata),
        .sum (w_rsum)
    );

endmodule
`default_nettype wire
